// File: rtl/snd_sample_fifo.sv
// Stereo L/R sample FIFO feeding the I2S serializer: shared write pointer,
// independent per-channel read pointers, FILL/RUN start-up gating.
module snd_sample_fifo #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int START_LEVEL = 512
) (
  input  logic          BCLK,
  input  logic          RST_X,
  input  logic          FLUSH,
  input  logic          STAT_CLR,
  input  logic          WR_EN,
  input  logic [15:0]   WR_L,
  input  logic [15:0]   WR_R,
  input  logic          FIFO_READ_L,
  input  logic          FIFO_READ_R,
  output logic [15:0]   L_SNDDATA,
  output logic [15:0]   R_SNDDATA,
  output logic [AW:0]   L_COUNT,
  output logic [AW:0]   R_COUNT,
  output logic          FIFO_FULL,
  output logic          PLAY_READY,
  output logic          OVERFLOW,
  output logic          UNDERRUN_L,
  output logic          UNDERRUN_R
);

  typedef enum logic {FILL, RUN} state_t;

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] START_CNT = (AW+1)'(START_LEVEL);

  state_t state, state_nxt;

  logic [15:0]   mem_l [DEPTH];
  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr_l, rd_ptr_r;
  logic          run, wr_acc, wr_drop;
  logic          pop_l, pop_r, under_l, under_r;

  always_comb begin
    run        = (state == RUN);
    PLAY_READY = run;
    FIFO_FULL  = (L_COUNT == FULL_CNT) || (R_COUNT == FULL_CNT);
    wr_acc     = WR_EN && !FIFO_FULL;
    wr_drop    = WR_EN && FIFO_FULL;
    pop_l      = run && FIFO_READ_L && (L_COUNT != '0);
    pop_r      = run && FIFO_READ_R && (R_COUNT != '0);
    under_l    = run && FIFO_READ_L && (L_COUNT == '0);
    under_r    = run && FIFO_READ_R && (R_COUNT == '0);
    state_nxt  = state;
    if (state == FILL && L_COUNT >= START_CNT)
      state_nxt = RUN;
  end

  always_ff @(posedge BCLK) begin
    if (!RST_X || FLUSH)
      state <= FILL;
    else
      state <= state_nxt;
  end

  // Storage is not reset; occupancy counts alone define which entries are valid.
  always_ff @(posedge BCLK) begin
    if (RST_X && !FLUSH && wr_acc) begin
      mem_l[wr_ptr] <= WR_L;
      mem_r[wr_ptr] <= WR_R;
    end
  end

  always_ff @(posedge BCLK) begin
    if (!RST_X) begin
      wr_ptr     <= '0;
      rd_ptr_l   <= '0;
      rd_ptr_r   <= '0;
      L_COUNT    <= '0;
      R_COUNT    <= '0;
      L_SNDDATA  <= '0;
      R_SNDDATA  <= '0;
      OVERFLOW   <= 1'b0;
      UNDERRUN_L <= 1'b0;
      UNDERRUN_R <= 1'b0;
    end else begin
      if (FLUSH) begin
        wr_ptr    <= '0;
        rd_ptr_l  <= '0;
        rd_ptr_r  <= '0;
        L_COUNT   <= '0;
        R_COUNT   <= '0;
        L_SNDDATA <= '0;
        R_SNDDATA <= '0;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop_l) begin
          L_SNDDATA <= mem_l[rd_ptr_l];
          rd_ptr_l  <= rd_ptr_l + AW'(1);
        end
        if (pop_r) begin
          R_SNDDATA <= mem_r[rd_ptr_r];
          rd_ptr_r  <= rd_ptr_r + AW'(1);
        end
        case ({wr_acc, pop_l})
          2'b10:   L_COUNT <= L_COUNT + (AW+1)'(1);
          2'b01:   L_COUNT <= L_COUNT - (AW+1)'(1);
          default: L_COUNT <= L_COUNT;
        endcase
        case ({wr_acc, pop_r})
          2'b10:   R_COUNT <= R_COUNT + (AW+1)'(1);
          2'b01:   R_COUNT <= R_COUNT - (AW+1)'(1);
          default: R_COUNT <= R_COUNT;
        endcase
      end
      // A new error event outranks STAT_CLR in the same cycle.
      OVERFLOW   <= (OVERFLOW   && !STAT_CLR) || (!FLUSH && wr_drop);
      UNDERRUN_L <= (UNDERRUN_L && !STAT_CLR) || (!FLUSH && under_l);
      UNDERRUN_R <= (UNDERRUN_R && !STAT_CLR) || (!FLUSH && under_r);
    end
  end

endmodule

// File: tb/tb_snd_sample_fifo.sv
// Bench for snd_sample_fifo (DEPTH=16, START_LEVEL=4): directed vector table,
// hand sequences for fill/wrap/flush, then random traffic against a queue model.
module tb_snd_sample_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SL    = 4;

  logic          BCLK = 1'b0;
  logic          RST_X = 1'b0, FLUSH = 1'b0, STAT_CLR = 1'b0, WR_EN = 1'b0;
  logic [15:0]   WR_L = '0, WR_R = '0;
  logic          FIFO_READ_L = 1'b0, FIFO_READ_R = 1'b0;
  logic [15:0]   L_SNDDATA, R_SNDDATA;
  logic [AW:0]   L_COUNT, R_COUNT;
  logic          FIFO_FULL, PLAY_READY, OVERFLOW, UNDERRUN_L, UNDERRUN_R;

  snd_sample_fifo #(.DEPTH(DEPTH), .AW(AW), .START_LEVEL(SL)) dut (
    .BCLK(BCLK), .RST_X(RST_X), .FLUSH(FLUSH), .STAT_CLR(STAT_CLR),
    .WR_EN(WR_EN), .WR_L(WR_L), .WR_R(WR_R),
    .FIFO_READ_L(FIFO_READ_L), .FIFO_READ_R(FIFO_READ_R),
    .L_SNDDATA(L_SNDDATA), .R_SNDDATA(R_SNDDATA),
    .L_COUNT(L_COUNT), .R_COUNT(R_COUNT), .FIFO_FULL(FIFO_FULL),
    .PLAY_READY(PLAY_READY), .OVERFLOW(OVERFLOW),
    .UNDERRUN_L(UNDERRUN_L), .UNDERRUN_R(UNDERRUN_R)
  );

  always #5 BCLK = ~BCLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: sample queues per channel plus a play flag.
  logic [15:0] ql[$];
  logic [15:0] qr[$];
  bit          m_run;
  logic [15:0] m_ld, m_rd;
  bit          m_ovf, m_unl, m_unr;

  typedef struct {
    logic        rst_x, flush, stclr, wen;
    logic [15:0] wl, wr;
    logic        rl, rr;
    int          lc, rc;
    logic [15:0] ld, rd;
    logic        play, full, ovf, unl, unr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst_x, flush, stclr, wen,
                             input logic [15:0] wl, wr, input logic rl, rr,
                             input int lc, rc, input logic [15:0] ld, rd,
                             input logic play, full, ovf, unl, unr);
    vec_t t;
    t.rst_x = rst_x; t.flush = flush; t.stclr = stclr; t.wen = wen;
    t.wl = wl; t.wr = wr; t.rl = rl; t.rr = rr;
    t.lc = lc; t.rc = rc; t.ld = ld; t.rd = rd;
    t.play = play; t.full = full; t.ovf = ovf; t.unl = unl; t.unr = unr;
    return t;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h required %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic model_update();
    if (!RST_X) begin
      ql.delete(); qr.delete();
      m_run = 0; m_ld = '0; m_rd = '0; m_ovf = 0; m_unl = 0; m_unr = 0;
    end else if (FLUSH) begin
      ql.delete(); qr.delete();
      m_run = 0; m_ld = '0; m_rd = '0;
      if (STAT_CLR) begin m_ovf = 0; m_unl = 0; m_unr = 0; end
    end else begin
      bit full, go, ul, ur, ov;
      full = (ql.size() == DEPTH) || (qr.size() == DEPTH);
      go   = m_run || (ql.size() >= SL);
      ul = 0; ur = 0; ov = 0;
      if (m_run && FIFO_READ_L) begin
        if (ql.size() > 0) m_ld = ql.pop_front(); else ul = 1;
      end
      if (m_run && FIFO_READ_R) begin
        if (qr.size() > 0) m_rd = qr.pop_front(); else ur = 1;
      end
      if (WR_EN) begin
        if (full) ov = 1;
        else begin ql.push_back(WR_L); qr.push_back(WR_R); end
      end
      m_ovf = (m_ovf && !STAT_CLR) || ov;
      m_unl = (m_unl && !STAT_CLR) || ul;
      m_unr = (m_unr && !STAT_CLR) || ur;
      m_run = go;
    end
  endtask

  task automatic compare_model();
    check("l_count", 32'(L_COUNT), 32'(ql.size()));
    check("r_count", 32'(R_COUNT), 32'(qr.size()));
    check("l_data", 32'(L_SNDDATA), 32'(m_ld));
    check("r_data", 32'(R_SNDDATA), 32'(m_rd));
    check("full", 32'(FIFO_FULL), 32'((ql.size() == DEPTH) || (qr.size() == DEPTH)));
    check("play_ready", 32'(PLAY_READY), 32'(m_run));
    check("overflow", 32'(OVERFLOW), 32'(m_ovf));
    check("underrun_l", 32'(UNDERRUN_L), 32'(m_unl));
    check("underrun_r", 32'(UNDERRUN_R), 32'(m_unr));
  endtask

  // Drive one cycle of inputs, let the edge happen, update model, sample #1 later.
  task automatic step(input logic rst_x, flush, stclr, wen, input logic [15:0] wl, wr,
                      input logic rl, rr, input bit chk);
    RST_X = rst_x; FLUSH = flush; STAT_CLR = stclr; WR_EN = wen;
    WR_L = wl; WR_R = wr; FIFO_READ_L = rl; FIFO_READ_R = rr;
    @(posedge BCLK);
    model_update();
    cyc++;
    #1;
    if (chk) compare_model();
  endtask

  initial begin
    // Fill gating, ordered drain, underrun/STAT_CLR, simultaneous write+read.
    tbl.push_back(v(0,0,0,0,16'h0,16'h0,0,0, 0,0,16'h0,16'h0,     0,0,0,0,0));
    tbl.push_back(v(1,0,0,1,16'h1,16'h101,0,0, 1,1,16'h0,16'h0,   0,0,0,0,0));
    tbl.push_back(v(1,0,0,1,16'h2,16'h102,0,0, 2,2,16'h0,16'h0,   0,0,0,0,0));
    tbl.push_back(v(1,0,0,1,16'h3,16'h103,1,0, 3,3,16'h0,16'h0,   0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,1,0, 3,3,16'h0,16'h0,     0,0,0,0,0));
    tbl.push_back(v(1,0,0,1,16'h4,16'h104,0,0, 4,4,16'h0,16'h0,   0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,0,0, 4,4,16'h0,16'h0,     1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,1,0, 3,4,16'h1,16'h0,     1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,0,1, 3,3,16'h1,16'h101,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,1,0, 2,3,16'h2,16'h101,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,0,1, 2,2,16'h2,16'h102,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,1,0, 1,2,16'h3,16'h102,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,0,1, 1,1,16'h3,16'h103,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,1,0, 0,1,16'h4,16'h103,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,0,1, 0,0,16'h4,16'h104,   1,0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h0,16'h0,0,1, 0,0,16'h4,16'h104,   1,0,0,0,1));
    tbl.push_back(v(1,0,1,0,16'h0,16'h0,0,0, 0,0,16'h4,16'h104,   1,0,0,0,0));
    tbl.push_back(v(1,0,1,0,16'h0,16'h0,0,1, 0,0,16'h4,16'h104,   1,0,0,0,1));
    tbl.push_back(v(1,0,0,1,16'h5,16'h105,1,0, 1,1,16'h4,16'h104, 1,0,0,1,1));
    tbl.push_back(v(1,0,0,1,16'h6,16'h106,1,0, 1,2,16'h5,16'h104, 1,0,0,1,1));

    foreach (tbl[i]) begin
      step(tbl[i].rst_x, tbl[i].flush, tbl[i].stclr, tbl[i].wen,
           tbl[i].wl, tbl[i].wr, tbl[i].rl, tbl[i].rr, 0);
      check($sformatf("vec%0d.l_count", i), 32'(L_COUNT), 32'(tbl[i].lc));
      check($sformatf("vec%0d.r_count", i), 32'(R_COUNT), 32'(tbl[i].rc));
      check($sformatf("vec%0d.l_data", i), 32'(L_SNDDATA), 32'(tbl[i].ld));
      check($sformatf("vec%0d.r_data", i), 32'(R_SNDDATA), 32'(tbl[i].rd));
      check($sformatf("vec%0d.play", i), 32'(PLAY_READY), 32'(tbl[i].play));
      check($sformatf("vec%0d.full", i), 32'(FIFO_FULL), 32'(tbl[i].full));
      check($sformatf("vec%0d.ovf", i), 32'(OVERFLOW), 32'(tbl[i].ovf));
      check($sformatf("vec%0d.unl", i), 32'(UNDERRUN_L), 32'(tbl[i].unl));
      check($sformatf("vec%0d.unr", i), 32'(UNDERRUN_R), 32'(tbl[i].unr));
    end

    // Flush with STAT_CLR, then fill to full plus one dropped write.
    step(1,1,1,0,16'h0,16'h0,0,0,1);
    check("flush_play", 32'(PLAY_READY), 32'h0);
    for (int k = 1; k <= 17; k++) begin
      step(1,0,0,1,16'(k),16'(k + 'h100),0,0,1);
      if (k == 15) check("not_full_at_15", 32'(FIFO_FULL), 32'h0);
      if (k == 16) check("full_at_16", 32'(FIFO_FULL), 32'h1);
    end
    check("ovf_after_17", 32'(OVERFLOW), 32'h1);
    check("l_count_capped", 32'(L_COUNT), 32'd16);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 1; k <= 16; k++) begin
        step(1,0,0,0,16'h0,16'h0,1,1,1);
        check($sformatf("pass%0d_l%0d", pass, k), 32'(L_SNDDATA), 32'(pass*16 + k));
        check($sformatf("pass%0d_r%0d", pass, k), 32'(R_SNDDATA), 32'(pass*16 + k + 'h100));
      end
      if (pass == 0)
        for (int k = 17; k <= 32; k++) step(1,0,0,1,16'(k),16'(k + 'h100),0,0,1);
    end
    check("drained_l", 32'(L_COUNT), 32'h0);

    // 8/8 in RUN with OVERFLOW held, then FLUSH+WR_EN, then reset.
    for (int k = 0; k < 8; k++) step(1,0,0,1,16'(k + 'h40),16'(k + 'h80),0,0,1);
    check("pre_flush_count", 32'(L_COUNT), 32'd8);
    check("pre_flush_play", 32'(PLAY_READY), 32'h1);
    step(1,1,0,1,16'hAAAA,16'h5555,0,0,1);
    check("flush_l_count", 32'(L_COUNT), 32'h0);
    check("flush_r_count", 32'(R_COUNT), 32'h0);
    check("flush_play_ready", 32'(PLAY_READY), 32'h0);
    check("flush_keeps_ovf", 32'(OVERFLOW), 32'h1);
    step(0,0,0,0,16'h0,16'h0,0,0,1);
    check("reset_ovf", 32'(OVERFLOW), 32'h0);
    check("reset_l_data", 32'(L_SNDDATA), 32'h0);

    // Random traffic with varying write pressure.
    for (int seg = 0; seg < 6; seg++) begin
      int wprob;
      wprob = (seg % 3 == 0) ? 75 : ((seg % 3 == 1) ? 30 : 55);
      for (int n = 0; n < 300; n++) begin
        step(1'b1,
             1'($urandom_range(0, 249) == 0),
             1'($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 99) < wprob),
             16'($urandom), 16'($urandom),
             1'($urandom_range(0, 99) < 45),
             1'($urandom_range(0, 99) < 45), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snd_sample_fifo.md
Name: snd_sample_fifo

Overview:
- Stereo sample buffer sitting directly upstream of the I2S output serializer.
- Accepts 16-bit L/R sample pairs from the capture/processing path. Serves them on the serializer's independent per-channel read strobes.
- Supports the serializer's rate modes (normal, double-rate reads, half-rate reads) and the delayed L-channel start.
- Independent L/R read pointers share one write pointer. A fill/run state machine prevents playback from starting on an empty buffer.

Parameters:
- DEPTH, 1024, samples per channel; must be a power of 2.
- AW, 10, pointer width; log2(DEPTH).
- START_LEVEL, 512, L occupancy required before leaving FILL; range 1..DEPTH.

Ports:
- BCLK  in  1  bit clock; the only clock.
- RST_X  in  1  synchronous active-low reset.
- FLUSH  in  1  synchronous flush: empties both channels and returns to FILL.
- STAT_CLR  in  1  clears sticky error flags.
- WR_EN  in  1  write one sample pair this cycle.
- WR_L  in  16  L sample to write.
- WR_R  in  16  R sample to write.
- FIFO_READ_L  in  1  pop one L sample (1-cycle pulse from the serializer).
- FIFO_READ_R  in  1  pop one R sample.
- L_SNDDATA  out  16  current L sample to the serializer.
- R_SNDDATA  out  16  current R sample to the serializer.
- L_COUNT  out  AW+1  L occupancy, 0..DEPTH.
- R_COUNT  out  AW+1  R occupancy, 0..DEPTH.
- FIFO_FULL  out  1  L_COUNT==DEPTH or R_COUNT==DEPTH.
- PLAY_READY  out  1  high in RUN state.
- OVERFLOW  out  1  sticky: a write was dropped.
- UNDERRUN_L  out  1  sticky: L read while L empty in RUN.
- UNDERRUN_R  out  1  sticky: R read while R empty in RUN.

Behaviour:
- Clock and reset:
  - Everything is sampled on posedge BCLK. Reset is synchronous and active-low (RST_X).
  - Reset values: all outputs 0; pointers 0; state FILL.
  - FLUSH has the same effect as reset, except OVERFLOW and UNDERRUN_L/UNDERRUN_R are retained.
  - RST_X has priority over FLUSH. FLUSH has priority over WR_EN and reads in the same cycle.
- Storage:
  - Two DEPTH x 16 arrays, L and R, written at a shared wr_ptr.
  - Separate rd_ptr_l and rd_ptr_r. All pointers wrap modulo DEPTH.
  - Counts are kept per channel as registers, not pointer differences.
- Write:
  - Accepted when WR_EN=1 and FIFO_FULL=0, judged on the registered counts. The pair is stored, wr_ptr+1, and each count+1 unless that channel pops in the same cycle.
  - WR_EN with FIFO_FULL=1: pair dropped, pointers unchanged, OVERFLOW<=1. This holds even if a read occurs in the same cycle.
- State machine:
  - FILL:
    - Reads are ignored: no pointer or count change, no underrun.
    - L_SNDDATA and R_SNDDATA are held at 0.
    - Leaves for RUN on the cycle after L_COUNT>=START_LEVEL. PLAY_READY rises with the state change.
  - RUN:
    - FIFO_READ_x with COUNT_x>0: x_SNDDATA <= array_x[rd_ptr_x] on that edge, so data is valid the cycle after the strobe. rd_ptr_x+1, count_x-1.
    - FIFO_READ_x with COUNT_x==0: x_SNDDATA holds its last value, pointer unchanged, UNDERRUN_x<=1.
    - RUN persists through underruns. Only FLUSH or reset return the block to FILL.
- Simultaneous events:
  - Write plus read on the same channel with count in 1..DEPTH-1: count unchanged, both pointers advance.
  - Write plus read on an empty channel: the read underruns (new data is not visible until the next cycle), and the write lands with count becoming 1.
  - L and R reads are fully independent. The double-rate and half-rate read patterns require no special handling.
- Status flags:
  - STAT_CLR clears the three sticky flags.
  - If STAT_CLR and a new error event occur in the same cycle, the flag ends up set.
- Read latency: exactly 1 BCLK from strobe to data. No combinational path from FIFO_READ_x to outputs.

Test Plan:
- DEPTH=16, START_LEVEL=4. Write 3 pairs (L=1,2,3 / R=0x101..0x103) and pulse FIFO_READ_L -> PLAY_READY=0, L_COUNT stays 3, L_SNDDATA=0, no UNDERRUN_L. Write a 4th pair -> PLAY_READY=1 on the next cycle.
- In RUN, alternate FIFO_READ_L and FIFO_READ_R four times -> L_SNDDATA=1,2,3,4 and R_SNDDATA=0x101..0x104, each valid one cycle after its strobe. Counts step down to 0.
- Write 17 pairs into an empty buffer -> FIFO_FULL=1 after the 16th write, the 17th is dropped, OVERFLOW=1. Reads then return values 1..16 with no gaps; the pointer wrap is checked on the second pass.
- In RUN with R_COUNT=0, pulse FIFO_READ_R -> R_SNDDATA holds its previous value and UNDERRUN_R=1. Then STAT_CLR -> flag clears. Issue STAT_CLR and an underrun together -> flag stays 1.
- With L_COUNT=1, apply WR_EN and FIFO_READ_L in the same cycle -> L_COUNT stays 1, old sample output. Repeat on an empty channel -> underrun, then L_COUNT=1.
- In RUN with counts 8/8 and OVERFLOW=1, assert FLUSH together with WR_EN -> counts 0, state FILL, PLAY_READY=0, OVERFLOW still 1. Then assert RST_X=0 for one cycle -> all outputs 0.
